// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU port, debug/loader port and memory-side signals of the unified
// instruction/data memory arbiter. The slave modport is the arbiter's view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ready;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ready;
    logic          dbg_lock;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_rdata, dbg_ready,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_rdata, dbg_ready,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory between the multicycle MIPS core and a
// debug/program-loader port; each transfer is IDLE -> WAIT x ACC -> RESP.
module mem_port_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    mem_port_arbiter_if.slave bus
);

    if (WAIT < 1 || WAIT > 15) begin : g_bad_wait
        $error("mem_port_arbiter: WAIT must be in 1..15");
    end

    localparam logic [3:0] LAST = 4'(WAIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_t;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t        state;
    owner_t        owner;
    owner_t        last_grant;
    logic [3:0]    cnt;
    logic          lat_we;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dbg_rdata_q;
    logic          cpu_ready_q;
    logic          dbg_ready_q;

    logic   cpu_elig;
    logic   dbg_elig;
    owner_t pick;
    req_t   sel;

    always_comb begin
        cpu_elig = bus.cpu_req & ~bus.dbg_lock;
        dbg_elig = bus.dbg_req;
        pick     = OWN_DBG;
        if (cpu_elig && dbg_elig)
            pick = (last_grant == OWN_CPU) ? OWN_DBG : OWN_CPU;
        else if (cpu_elig)
            pick = OWN_CPU;
        if (pick == OWN_CPU)
            sel = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
        else
            sel = '{we: bus.dbg_we, addr: bus.dbg_addr, wdata: bus.dbg_wdata};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            owner       <= OWN_DBG;
            last_grant  <= OWN_DBG;
            lat_we      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            dbg_ready_q <= 1'b0;
        end else begin
            cpu_ready_q <= 1'b0;
            dbg_ready_q <= 1'b0;
            we_q        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_elig || dbg_elig) begin
                        owner      <= pick;
                        last_grant <= pick;
                        lat_we     <= sel.we;
                        addr_q     <= sel.addr;
                        wdata_q    <= sel.wdata;
                        cnt        <= '0;
                        // a single-cycle access strobes in its first ACC cycle
                        we_q       <= sel.we && (LAST == 4'd0);
                        state      <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= S_RESP;
                        if (owner == OWN_CPU) begin
                            cpu_ready_q <= 1'b1;
                            if (!lat_we) cpu_rdata_q <= bus.mem_rdata;
                        end else begin
                            dbg_ready_q <= 1'b1;
                            if (!lat_we) dbg_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        cnt  <= cnt + 4'd1;
                        we_q <= lat_we && (cnt + 4'd1 == LAST);
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reset landing on the strobe cycle must not let the memory commit the write.
    assign bus.mem_we    = we_q & resetn;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.dbg_ready = dbg_ready_q;
    assign bus.busy      = (state != S_IDLE);

    a_ready_onehot: assert property (@(posedge clk) disable iff (!resetn)
        !(bus.cpu_ready && bus.dbg_ready));
    a_we_in_acc: assert property (@(posedge clk) disable iff (!resetn)
        bus.mem_we |-> (state == S_ACC && cnt == LAST));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter: a WAIT=2 instance carries
// most scenarios, a WAIT=1 instance covers single-cycle access timing.
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, WAIT_A = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) a ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) b ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT_A)) u_w2 (.clk(clk), .resetn(resetn), .bus(a.slave));
    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(1))      u_w1 (.clk(clk), .resetn(resetn), .bus(b.slave));

    // memory array seen by the WAIT=2 instance; the WAIT=1 one reads an address pattern
    logic [31:0] mem_a [0:255];
    int          we_a = 0;
    logic [31:0] we_a_addr = '0;
    assign a.mem_rdata = mem_a[a.mem_addr[9:2]];
    assign b.mem_rdata = 32'h1111_0000 ^ b.mem_addr;
    always @(posedge clk) begin
        if (a.mem_we) begin
            mem_a[a.mem_addr[9:2]] <= a.mem_wdata;
            we_a      <= we_a + 1;
            we_a_addr <= a.mem_addr;
        end
    end

    // reference model: memory contents, last granted port, per-port held read data
    logic [31:0] ref_mem [0:255];
    bit          m_last_dbg;
    logic [31:0] m_cpu_rd, m_dbg_rd;
    int passed = 0, checks = 0;

    task automatic do_reset();
        {a.cpu_req, a.cpu_we, a.dbg_req, a.dbg_we, a.dbg_lock} = '0;
        {a.cpu_addr, a.cpu_wdata, a.dbg_addr, a.dbg_wdata} = '0;
        {b.cpu_req, b.cpu_we, b.dbg_req, b.dbg_we, b.dbg_lock} = '0;
        {b.cpu_addr, b.cpu_wdata, b.dbg_addr, b.dbg_wdata} = '0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        m_last_dbg = 1'b1;
        m_cpu_rd = '0;
        m_dbg_rd = '0;
    endtask

    // One access on either or both ports of the WAIT=2 instance, checked against the model.
    task automatic run_acc(input bit uc, input bit ud,
                           input bit cwe, input logic [31:0] cad, input logic [31:0] cwd,
                           input bit dwe, input logic [31:0] dad, input logic [31:0] dwd,
                           input bit scr);
        bit fd, isd;
        int ec = -1, ed = -1, gc = -1, gd = -1, nc = 0, nd = 0, ew = 0, w0, lat;
        fd = (uc && ud) ? !m_last_dbg : ud;
        for (int k = 0; k < 2; k++) begin
            isd = (k == 0) ? fd : !fd;
            lat = (WAIT_A + 1) + k * (WAIT_A + 2);
            if (isd && ud) begin
                ed = lat; m_last_dbg = 1'b1;
                if (dwe) begin ref_mem[dad[9:2]] = dwd; ew++; end
                else m_dbg_rd = ref_mem[dad[9:2]];
            end else if (!isd && uc) begin
                ec = lat; m_last_dbg = 1'b0;
                if (cwe) begin ref_mem[cad[9:2]] = cwd; ew++; end
                else m_cpu_rd = ref_mem[cad[9:2]];
            end
        end
        w0 = we_a;
        @(posedge clk); #1;
        a.cpu_req = uc; a.cpu_we = cwe; a.cpu_addr = cad; a.cpu_wdata = cwd;
        a.dbg_req = ud; a.dbg_we = dwe; a.dbg_addr = dad; a.dbg_wdata = dwd;
        for (int n = 0; n < 4 * WAIT_A + 12; n++) begin
            @(negedge clk);
            if (a.cpu_ready) begin nc++; if (gc < 0) gc = n; end
            if (a.dbg_ready) begin nd++; if (gd < 0) gd = n; end
            @(posedge clk); #1;
            if (gc == n) a.cpu_req = 1'b0;
            if (gd == n) a.dbg_req = 1'b0;
            // once granted, the live payload must no longer matter
            if (scr && a.cpu_req && ec >= 0 && n >= ec - (WAIT_A + 1)) begin
                a.cpu_we = 1'($urandom); a.cpu_addr = $urandom; a.cpu_wdata = $urandom;
            end
            if (scr && a.dbg_req && ed >= 0 && n >= ed - (WAIT_A + 1)) begin
                a.dbg_we = 1'($urandom); a.dbg_addr = $urandom; a.dbg_wdata = $urandom;
            end
            if ((!uc || gc >= 0) && (!ud || gd >= 0)) break;
        end
        checks++; if (gc !== ec) $display("FAIL cpu_latency: got %0d expected %0d", gc, ec); else passed++;
        checks++; if (gd !== ed) $display("FAIL dbg_latency: got %0d expected %0d", gd, ed); else passed++;
        checks++; if (nc !== int'(uc)) $display("FAIL cpu_ready_count: got %0d expected %0d", nc, int'(uc)); else passed++;
        checks++; if (nd !== int'(ud)) $display("FAIL dbg_ready_count: got %0d expected %0d", nd, int'(ud)); else passed++;
        checks++; if (a.cpu_rdata !== m_cpu_rd) $display("FAIL cpu_rdata: got %h expected %h", a.cpu_rdata, m_cpu_rd); else passed++;
        checks++; if (a.dbg_rdata !== m_dbg_rd) $display("FAIL dbg_rdata: got %h expected %h", a.dbg_rdata, m_dbg_rd); else passed++;
        checks++; if (we_a - w0 !== ew) $display("FAIL write_strobes: got %0d expected %0d", we_a - w0, ew); else passed++;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if ({a.busy, a.mem_we, a.cpu_ready, a.dbg_ready} !== 4'b0) $display("FAIL reset_ctl_a: got %b expected 0000", {a.busy, a.mem_we, a.cpu_ready, a.dbg_ready}); else passed++;
        checks++; if ({a.mem_addr, a.mem_wdata} !== 64'h0) $display("FAIL reset_mem_a: got %h expected 0", {a.mem_addr, a.mem_wdata}); else passed++;
        checks++; if ({a.cpu_rdata, a.dbg_rdata} !== 64'h0) $display("FAIL reset_rdata_a: got %h expected 0", {a.cpu_rdata, a.dbg_rdata}); else passed++;
        checks++; if ({b.busy, b.mem_we, b.cpu_ready, b.dbg_ready} !== 4'b0) $display("FAIL reset_ctl_b: got %b expected 0000", {b.busy, b.mem_we, b.cpu_ready, b.dbg_ready}); else passed++;
    endtask

    task automatic test_cpu_read();
        run_acc(0, 1, 0, '0, '0, 1, 32'h40, 32'h0000_1234, 0);
        run_acc(1, 0, 0, 32'h40, '0, 0, '0, '0, 0);
        checks++; if (a.cpu_rdata !== 32'h0000_1234) $display("FAIL cpu_read_0x40: got %h expected 00001234", a.cpu_rdata); else passed++;
    endtask

    task automatic test_write_readback();
        run_acc(1, 0, 1, 32'h80, 32'hDEAD_BEEF, 0, '0, '0, 0);
        checks++; if (we_a_addr !== 32'h80) $display("FAIL strobe_addr: got %h expected 00000080", we_a_addr); else passed++;
        run_acc(0, 1, 0, '0, '0, 0, 32'h80, '0, 0);
        checks++; if (a.dbg_rdata !== 32'hDEAD_BEEF) $display("FAIL dbg_readback: got %h expected deadbeef", a.dbg_rdata); else passed++;
    endtask

    task automatic test_round_robin();
        int ev_n[4];
        bit ev_d[4];
        int ne = 0;
        do_reset();
        @(posedge clk); #1;
        a.cpu_req = 1; a.cpu_addr = 32'h40; a.dbg_req = 1; a.dbg_addr = 32'h80;
        for (int n = 0; n < 40 && ne < 4; n++) begin
            @(negedge clk);
            if (a.cpu_ready && ne < 4) begin ev_n[ne] = n; ev_d[ne] = 0; ne++; end
            if (a.dbg_ready && ne < 4) begin ev_n[ne] = n; ev_d[ne] = 1; ne++; end
        end
        @(posedge clk); #1;
        a.cpu_req = 0; a.dbg_req = 0;
        checks++; if (ne !== 4) $display("FAIL rr_events: got %0d expected 4", ne); else passed++;
        for (int k = 0; k < ne; k++) begin
            checks++; if (ev_d[k] !== bit'(k % 2)) $display("FAIL rr_order[%0d]: got dbg=%0d expected dbg=%0d", k, ev_d[k], k % 2); else passed++;
            checks++; if (ev_n[k] !== (WAIT_A + 1) + k * (WAIT_A + 2)) $display("FAIL rr_cycle[%0d]: got %0d expected %0d", k, ev_n[k], (WAIT_A + 1) + k * (WAIT_A + 2)); else passed++;
        end
        m_last_dbg = 1'b1; m_cpu_rd = ref_mem[8'h10]; m_dbg_rd = ref_mem[8'h20];
        checks++; if (a.cpu_rdata !== m_cpu_rd) $display("FAIL rr_cpu_rdata: got %h expected %h", a.cpu_rdata, m_cpu_rd); else passed++;
        checks++; if (a.dbg_rdata !== m_dbg_rd) $display("FAIL rr_dbg_rdata: got %h expected %h", a.dbg_rdata, m_dbg_rd); else passed++;
    endtask

    task automatic test_lock();
        int nd = 0, nc = 0, n5 = -1, lat = -1;
        @(posedge clk); #1;
        a.dbg_lock = 1;
        a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 32'h40;
        a.dbg_req = 1; a.dbg_we = 0; a.dbg_addr = 32'h80;
        for (int n = 0; n < 40 && nd < 5; n++) begin
            @(negedge clk);
            if (a.cpu_ready) nc++;
            if (a.dbg_ready) begin nd++; if (nd == 5) n5 = n; end
        end
        @(posedge clk); #1;
        a.dbg_req = 0; a.dbg_lock = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (a.cpu_ready) begin lat = n; break; end
        end
        @(posedge clk); #1;
        a.cpu_req = 0;
        checks++; if (nd !== 5) $display("FAIL lock_dbg_count: got %0d expected 5", nd); else passed++;
        checks++; if (nc !== 0) $display("FAIL lock_cpu_count: got %0d expected 0", nc); else passed++;
        checks++; if (n5 !== 4 * (WAIT_A + 2) + WAIT_A + 1) $display("FAIL lock_5th_cycle: got %0d expected %0d", n5, 4 * (WAIT_A + 2) + WAIT_A + 1); else passed++;
        checks++; if (lat !== WAIT_A + 1) $display("FAIL unlock_latency: got %0d expected %0d", lat, WAIT_A + 1); else passed++;
        m_last_dbg = 1'b0; m_cpu_rd = ref_mem[8'h10]; m_dbg_rd = ref_mem[8'h20];
        checks++; if (a.cpu_rdata !== m_cpu_rd) $display("FAIL lock_cpu_rdata: got %h expected %h", a.cpu_rdata, m_cpu_rd); else passed++;
    endtask

    task automatic test_reset_mid_write();
        int w0, nr = 0;
        run_acc(0, 1, 0, '0, '0, 1, 32'h100, 32'hCAFE_F00D, 0);
        w0 = we_a;
        @(posedge clk); #1;
        a.cpu_req = 1; a.cpu_we = 1; a.cpu_addr = 32'h100; a.cpu_wdata = 32'h0000_55AA;
        @(posedge clk);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (a.mem_we !== 1'b0) $display("FAIL abort_mem_we: got %b expected 0", a.mem_we); else passed++;
        @(posedge clk); #1;
        resetn = 1'b1; a.cpu_req = 0; a.cpu_we = 0;
        m_last_dbg = 1'b1; m_cpu_rd = '0; m_dbg_rd = '0;
        @(negedge clk);
        checks++; if (a.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", a.busy); else passed++;
        checks++; if (a.cpu_rdata !== 32'h0) $display("FAIL abort_rdata: got %h expected 0", a.cpu_rdata); else passed++;
        for (int n = 0; n < 4; n++) begin
            if (a.cpu_ready || a.dbg_ready) nr++;
            @(negedge clk);
        end
        checks++; if (nr !== 0) $display("FAIL abort_ready: got %0d expected 0", nr); else passed++;
        checks++; if (we_a - w0 !== 0) $display("FAIL abort_strobes: got %0d expected 0", we_a - w0); else passed++;
        run_acc(1, 0, 0, 32'h100, '0, 0, '0, '0, 0);
        checks++; if (a.cpu_rdata !== 32'hCAFE_F00D) $display("FAIL abort_readback: got %h expected cafef00d", a.cpu_rdata); else passed++;
    endtask

    task automatic test_wait1();
        int k = 0;
        logic [31:0] exp;
        @(posedge clk); #1;
        b.cpu_req = 1; b.cpu_we = 0; b.cpu_addr = 32'h0;
        for (int n = 0; n < 20 && k < 3; n++) begin
            @(negedge clk);
            if (b.cpu_ready) begin
                exp = 32'h1111_0000 ^ 32'(4 * k);
                checks++; if (n !== 2 + 3 * k) $display("FAIL w1_cycle[%0d]: got %0d expected %0d", k, n, 2 + 3 * k); else passed++;
                checks++; if (b.cpu_rdata !== exp) $display("FAIL w1_rdata[%0d]: got %h expected %h", k, b.cpu_rdata, exp); else passed++;
                k++;
                @(posedge clk); #1;
                b.cpu_addr = 32'(4 * k);
            end else if (k > 0) begin
                exp = 32'h1111_0000 ^ 32'(4 * (k - 1));
                checks++; if (b.cpu_rdata !== exp) $display("FAIL w1_hold: got %h expected %h", b.cpu_rdata, exp); else passed++;
            end
        end
        @(posedge clk); #1;
        b.cpu_req = 0;
        checks++; if (k !== 3) $display("FAIL w1_count: got %0d expected 3", k); else passed++;
    endtask

    task automatic test_random();
        int ch;
        for (int i = 0; i < 8; i++)
            run_acc(0, 1, 0, '0, '0, 1, 32'h200 + 32'(4 * i), $urandom, 1);
        for (int i = 0; i < 40; i++) begin
            ch = $urandom_range(0, 2);
            run_acc(ch != 1, ch != 0,
                    1'($urandom), 32'h200 + 32'(4 * $urandom_range(0, 7)), $urandom,
                    1'($urandom), 32'h200 + 32'(4 * $urandom_range(0, 7)), $urandom, 1);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_write_readback();
        test_round_robin();
        test_lock();
        test_reset_mid_write();
        test_wait1();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
